// File: rtl/alpha_pkg.sv
// Shared alphacore definitions: program loader state encoding and core word defaults.
package alpha_pkg;

   localparam int          XLEN     = 32;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } load_state_e;

endpackage

// File: rtl/prog_mem_ram.sv
// Program storage: one synchronous write port, one combinational read port, no reset on contents.
module prog_mem_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/prog_mem_loader.sv
// Program memory loader: streams an image in, back-fills the rest with FILL_WORD,
// then releases the core and serves combinational instruction fetches.
module prog_mem_loader
   import alpha_pkg::*;
#(
   parameter int                DATA_W    = XLEN,
   parameter int                DEPTH     = 256,
   parameter int                ADDR_W    = $clog2(DEPTH),
   parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(NOP_WORD)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              reload,
   input  logic [31:0]       fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_oob,
   output logic              fetch_misaligned,
   output logic              core_rst_n,
   output logic              load_done,
   output logic [ADDR_W:0]   load_count
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);

   // state is the FSM observation point for checkers
   load_state_e       state, state_d;
   logic [ADDR_W:0]   load_count_q, load_count_d;
   logic [ADDR_W:0]   fill_ptr_q, fill_ptr_d;
   logic              core_rst_n_q, load_done_q;
   logic              hs;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic [ADDR_W-1:0] fetch_index;

   // Handshake: a word transfers on a rising edge where load_valid and load_ready are both high;
   // load_data/load_last are only meaningful while load_valid is high, ready never waits on valid.
   assign load_ready = (state == LOAD) && rst_n;
   assign hs         = load_valid && load_ready;

   always_comb begin
      state_d      = state;
      load_count_d = load_count_q;
      fill_ptr_d   = fill_ptr_q;
      ram_we       = 1'b0;
      ram_waddr    = load_count_q[ADDR_W-1:0];
      ram_wdata    = load_data;
      if (reload) begin
         // reload wins over a same-cycle handshake, so that word is dropped
         state_d      = LOAD;
         load_count_d = '0;
      end else begin
         case (state)
            LOAD: begin
               if (hs) begin
                  ram_we       = 1'b1;
                  load_count_d = load_count_q + 1'b1;
                  if (load_last || (load_count_d == DEPTH_CNT)) begin
                     state_d    = FILL;
                     fill_ptr_d = load_count_d;
                  end
               end
            end
            FILL: begin
               // pointer MSB set means a full image: nothing left to back-fill
               if (fill_ptr_q[ADDR_W]) begin
                  state_d = RUN;
               end else begin
                  ram_we     = 1'b1;
                  ram_waddr  = fill_ptr_q[ADDR_W-1:0];
                  ram_wdata  = FILL_WORD;
                  fill_ptr_d = fill_ptr_q + 1'b1;
                  if (fill_ptr_q == LAST_IDX) state_d = RUN;
               end
            end
            RUN:     ;
            default: state_d = LOAD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= LOAD;
         load_count_q <= '0;
         fill_ptr_q   <= '0;
         core_rst_n_q <= 1'b0;
         load_done_q  <= 1'b0;
      end else begin
         state        <= state_d;
         load_count_q <= load_count_d;
         fill_ptr_q   <= fill_ptr_d;
         core_rst_n_q <= (state_d == RUN);
         load_done_q  <= (state_d == RUN);
      end
   end

   prog_mem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (fetch_index),
      .rdata (ram_rdata)
   );

   assign fetch_index      = fetch_addr[ADDR_W+1:2];
   assign fetch_oob        = |fetch_addr[31:ADDR_W+2];
   assign fetch_misaligned = |fetch_addr[1:0];
   assign fetch_data       = ((state != RUN) || fetch_oob) ? FILL_WORD : ram_rdata;

   assign core_rst_n = core_rst_n_q;
   assign load_done  = load_done_q;
   assign load_count = load_count_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: a 256-deep instance for the program image and a 4-deep one for the full case.
module tb_prog_mem_loader;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        a_load_valid, a_load_ready, a_load_last, a_reload;
   logic [31:0] a_load_data, a_fetch_addr, a_fetch_data;
   logic        a_fetch_oob, a_fetch_misaligned, a_core_rst_n, a_load_done;
   logic [8:0]  a_load_count;

   logic        b_load_valid, b_load_ready, b_load_last, b_reload;
   logic [31:0] b_load_data, b_fetch_addr, b_fetch_data;
   logic        b_fetch_oob, b_fetch_misaligned, b_core_rst_n, b_load_done;
   logic [2:0]  b_load_count;

   prog_mem_loader #(.DEPTH(256)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .load_valid(a_load_valid), .load_ready(a_load_ready), .load_data(a_load_data),
      .load_last(a_load_last), .reload(a_reload), .fetch_addr(a_fetch_addr),
      .fetch_data(a_fetch_data), .fetch_oob(a_fetch_oob), .fetch_misaligned(a_fetch_misaligned),
      .core_rst_n(a_core_rst_n), .load_done(a_load_done), .load_count(a_load_count)
   );

   prog_mem_loader #(.DEPTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .load_valid(b_load_valid), .load_ready(b_load_ready), .load_data(b_load_data),
      .load_last(b_load_last), .reload(b_reload), .fetch_addr(b_fetch_addr),
      .fetch_data(b_fetch_data), .fetch_oob(b_fetch_oob), .fetch_misaligned(b_fetch_misaligned),
      .core_rst_n(b_core_rst_n), .load_done(b_load_done), .load_count(b_load_count)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] prog [38];
   logic [31:0] img  [256];
   logic [31:0] bw   [6];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive n words of img; gaps inserts an idle cycle (junk data/last) before each word
   task automatic load_a(input int n, input bit gaps, input bit scored);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            a_load_valid = 1'b0;
            a_load_data  = $urandom;
            a_load_last  = 1'($urandom_range(0, 1));
            tick();
         end
         a_load_valid = 1'b1;
         a_load_data  = img[i];
         a_load_last  = (i == n - 1);
         tick();
         if (scored) exp_q.push_back(img[i]);
      end
      a_load_valid = 1'b0;
      a_load_last  = 1'b0;
      if (scored) for (int i = n; i < 256; i++) exp_q.push_back(NOP);
   endtask

   task automatic pulse_reload();
      a_reload = 1'b1;
      tick();
      a_reload = 1'b0;
   endtask

   task automatic wait_run(input int budget, output int cycles);
      cycles = 0;
      while (a_core_rst_n !== 1'b1 && cycles < budget) begin
         tick();
         cycles++;
      end
      check("run_reached", a_core_rst_n, 1);
   endtask

   task automatic fetch_a(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      @(negedge clk);
      a_fetch_addr = addr;
      #1;
      check(tag, a_fetch_data, exp);
   endtask

   task automatic dump_a(input string tag);
      check({tag, "_exp_q_size"}, exp_q.size(), 256);
      for (int i = 0; i < 256 && exp_q.size() > 0; i++) begin
         fetch_a($sformatf("%s[%0d]", tag, i), 32'(i * 4), exp_q.pop_front());
      end
   endtask

   initial begin
      int n;
      rst_n        = 1'b0;
      a_load_valid = 1'b0; a_load_last = 1'b0; a_reload = 1'b0;
      a_load_data  = '0;   a_fetch_addr = '0;
      b_load_valid = 1'b0; b_load_last = 1'b0; b_reload = 1'b0;
      b_load_data  = '0;   b_fetch_addr = '0;
      for (int i = 0; i < 38; i++) prog[i] = $urandom;
      prog[0]  = 32'h0000_06b3;
      prog[37] = 32'h0000_0033;
      for (int i = 0; i < 38; i++) img[i] = prog[i];
      for (int i = 0; i < 6; i++) bw[i] = $urandom;

      // reset values
      #12;
      check("rst_core_rst_n", a_core_rst_n, 0);
      check("rst_load_ready", a_load_ready, 0);
      check("rst_load_done", a_load_done, 0);
      check("rst_load_count", a_load_count, 0);
      check("rst_fetch_data", a_fetch_data, NOP);
      check("rst_b_load_ready", b_load_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_ready", a_load_ready, 1);

      // 38-word image, valid held high
      load_a(38, 1'b0, 1'b1);
      check("img1_ready_fall", a_load_ready, 0);
      check("img1_count", a_load_count, 38);
      check("img1_core_held", a_core_rst_n, 0);
      wait_run(1000, n);
      check("img1_fill_cycles", n, 218);
      check("img1_load_done", a_load_done, 1);
      fetch_a("img1_f00", 32'h00, 32'h0000_06b3);
      fetch_a("img1_f94", 32'h94, 32'h0000_0033);
      fetch_a("img1_f98", 32'h98, NOP);
      fetch_a("img1_f3fc", 32'h3FC, NOP);
      dump_a("img1");

      // backpressure reload
      pulse_reload();
      check("rl_core_rst_n", a_core_rst_n, 0);
      check("rl_load_done", a_load_done, 0);
      check("rl_count", a_load_count, 0);
      check("rl_ready", a_load_ready, 1);
      load_a(38, 1'b1, 1'b1);
      wait_run(1000, n);
      check("img2_count", a_load_count, 38);
      dump_a("img2");

      // fetch flags
      @(negedge clk);
      a_fetch_addr = 32'h400;
      #1;
      check("oob_flag", a_fetch_oob, 1);
      check("oob_data", a_fetch_data, NOP);
      check("oob_misaligned", a_fetch_misaligned, 0);
      @(negedge clk);
      a_fetch_addr = 32'h06;
      #1;
      check("mis_flag", a_fetch_misaligned, 1);
      check("mis_oob", a_fetch_oob, 0);
      check("mis_data", a_fetch_data, prog[1]);

      // reload during FILL, then a 2-word image
      pulse_reload();
      load_a(38, 1'b0, 1'b0);
      repeat (5) tick();
      check("fill_core_held", a_core_rst_n, 0);
      check("fill_ready_low", a_load_ready, 0);
      pulse_reload();
      check("rlf_core_rst_n", a_core_rst_n, 0);
      check("rlf_count", a_load_count, 0);
      check("rlf_ready", a_load_ready, 1);
      check("rlf_fetch_nop", a_fetch_data, NOP);
      img[0] = 32'hCAFE_0001;
      img[1] = 32'hBEEF_0002;
      load_a(2, 1'b0, 1'b1);
      wait_run(1000, n);
      check("img3_fill_cycles", n, 254);
      dump_a("img3");

      // full condition on the 4-deep instance, no load_last
      for (int i = 0; i < 6; i++) begin
         b_load_valid = 1'b1;
         b_load_data  = bw[i];
         b_load_last  = 1'b0;
         tick();
         if (i < 4) exp_q.push_back(bw[i]);
         if (i == 3) begin
            check("full_ready_low", b_load_ready, 0);
            check("full_count", b_load_count, 4);
            check("full_core_held", b_core_rst_n, 0);
         end
         if (i == 4) begin
            check("full_run_core", b_core_rst_n, 1);
            check("full_run_done", b_load_done, 1);
         end
      end
      b_load_valid = 1'b0;
      check("full_count_final", b_load_count, 4);
      check("full_exp_q_size", exp_q.size(), 4);
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         b_fetch_addr = 32'(i * 4);
         #1;
         check($sformatf("full[%0d]", i), b_fetch_data, exp_q.pop_front());
      end
      @(negedge clk);
      b_fetch_addr = 32'h10;
      #1;
      check("full_oob_flag", b_fetch_oob, 1);
      check("full_oob_data", b_fetch_data, NOP);

      // async reset between edges while in RUN
      a_fetch_addr = 32'h0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_run_core", a_core_rst_n, 0);
      check("arst_run_done", a_load_done, 0);
      check("arst_run_fetch", a_fetch_data, NOP);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // async reset between edges in mid-LOAD
      for (int i = 0; i < 10; i++) begin
         a_load_valid = 1'b1;
         a_load_data  = $urandom;
         tick();
      end
      check("mid_count", a_load_count, 10);
      a_load_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_load_ready", a_load_ready, 0);
      check("arst_load_core", a_core_rst_n, 0);
      check("arst_load_count", a_load_count, 0);
      check("arst_load_fetch", a_fetch_data, NOP);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 38; i++) img[i] = prog[i];
      load_a(38, 1'b0, 1'b1);
      wait_run(1000, n);
      check("img4_fill_cycles", n, 218);
      dump_a("img4");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Parametrised program memory for the alphacore bench and FPGA top; it replaces the static testbench array initialisation.
- A program is streamed in word by word over a valid/ready port, and unloaded locations are back-filled with a configurable fill word.
- The core is held in reset until the image is complete, then the block serves combinational instruction fetches.
- A reload request returns the block to load mode without a global reset.

Parameters:
- DATA_W, 32, instruction/data word width in bits.
- DEPTH, 256, number of words; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), word index width (derived, do not override).
- FILL_WORD, 32'h00000013, value written to every unloaded word (RV32I NOP).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  load_data/load_last valid this cycle.
- load_ready  out  1  block accepts a word this cycle.
- load_data  in  DATA_W  program word, written at index load_count.
- load_last  in  1  qualifies the final word of the image.
- reload  in  1  single-cycle request to restart loading.
- fetch_addr  in  32  byte address from the core.
- fetch_data  out  DATA_W  instruction word (combinational).
- fetch_oob  out  1  fetch_addr is beyond DEPTH*4 bytes.
- fetch_misaligned  out  1  fetch_addr[1:0] != 0.
- core_rst_n  out  1  active-low reset to the core; high only in RUN.
- load_done  out  1  high in RUN.
- load_count  out  ADDR_W+1  words accepted since the last reset/reload.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD, load_count=0, fill pointer=0.
  - core_rst_n=0, load_done=0, load_ready=0 while rst_n is low.
  - Memory contents are not reset.
- LOAD state:
  - load_ready=1.
  - Handshake = load_valid & load_ready; on a handshake, mem[load_count]<=load_data and load_count increments.
  - load_data may change freely while load_valid=0.
  - Handshake with load_last=1: go to FILL with fill pointer=load_count+1.
  - Handshake where load_count becomes DEPTH: go to FILL regardless of load_last. This is the full condition.
  - In FILL, load_ready=0; further load_valid is ignored with no write and no count change.
- FILL state:
  - load_ready=0.
  - Each cycle writes FILL_WORD at the fill pointer and increments it.
  - After writing index DEPTH-1, go to RUN next cycle.
  - If FILL is entered with fill pointer=DEPTH, go to RUN next cycle with no writes.
  - Fill time = DEPTH - words loaded, in cycles.
- RUN state:
  - core_rst_n=1 and load_done=1, both registered, asserted the cycle after the last fill write.
  - Memory is read-only.
- reload=1, any state: next state=LOAD, load_count=0, core_rst_n=0, load_done=0.
  - reload takes priority over a simultaneous handshake; that word is dropped.
- Fetch path (combinational):
  - index = fetch_addr[ADDR_W+1:2].
  - fetch_oob = |fetch_addr[31:ADDR_W+2].
  - fetch_misaligned = |fetch_addr[1:0]; data still comes from the truncated index.
  - fetch_data = FILL_WORD when state != RUN or fetch_oob=1; otherwise mem[index].
- Reset mid-LOAD or mid-FILL: restart from LOAD; stale memory is overwritten by the next load and fill.

Decomposition:
- Package alpha_pkg holds:
  - the state enum {LOAD, FILL, RUN};
  - the constant NOP_WORD = 32'h00000013;
  - the default XLEN = 32.
- One sub-module, prog_mem_ram: DEPTH x DATA_W array with a single synchronous write port and a combinational read port.
- The FSM, counters and fetch muxing live in prog_mem_loader.

Test Plan:
- Load the 38-word sort program (first word 000006b3, last word 00000033 with load_last) with valid held high, DEPTH=256:
  - load_ready falls after the 38th handshake;
  - core_rst_n rises 218 cycles later;
  - fetch 0x00 -> 000006b3, 0x94 -> 00000033, 0x98 -> 00000013, 0x3FC -> 00000013.
- Backpressure: same image with load_valid toggling every other cycle -> identical memory image; load_count=38 at RUN.
- Full, DEPTH=4: send 6 words without load_last:
  - only the first 4 are written and load_count=4;
  - no FILL writes occur and RUN is entered the cycle after FILL;
  - words 5-6 are never accepted.
- Fetch flags in RUN:
  - fetch 0x400 with DEPTH=256 -> fetch_oob=1, data 00000013;
  - fetch 0x06 -> fetch_misaligned=1, data = mem[1].
- Reload during FILL:
  - core_rst_n stays 0 and load_count=0 the next cycle;
  - a 2-word reload then yields mem[0..1]=new words and mem[2..] = 00000013.
- Async reset asserted mid-LOAD between clock edges:
  - core_rst_n and load_ready go 0 immediately without waiting for a clock edge;
  - fetch_data = 00000013;
  - after release a fresh load completes normally.
